// File: rtl/staff_pkg.sv
// Shared staff-image definitions used by the MIDI recorder and the staff player.
package staff_pkg;

    localparam int NUM_VOICES = 5;
    localparam int NUM_CELLS  = 64;
    localparam int VIDX_W     = $clog2(NUM_VOICES);

    // Kind 15 never occurs for a real note, so it marks an empty cell.
    localparam logic [11:0] REST_CODE = 12'h0F0;

    typedef struct packed {
        logic [3:0] dur;
        logic [3:0] kind;
        logic [3:0] octave;
    } staff_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RECORD,
        ST_FLUSH,
        ST_DONE
    } staff_state_t;

    typedef struct packed {
        logic       active;
        logic       rel;
        logic [6:0] note;
        logic [3:0] held;
    } voice_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'h1;
    endfunction

endpackage

// File: rtl/midi_note_split.sv
// Splits a 7-bit MIDI note into octave (note/12) and pitch class (note%12).
module midi_note_split (
    input  logic [6:0] note,
    output logic [3:0] octave,
    output logic [3:0] kind
);

    // Threshold compare against multiples of 12 stands in for a divider.
    always_comb begin
        octave = '0;
        for (int i = 1; i < 11; i++)
            if (note >= 7'(12 * i)) octave = 4'(i);
    end

    assign kind = 4'(note - 7'(12 * octave));

endmodule

// File: rtl/midi_staff_writer.sv
// Records live MIDI note on/off events into a quantized 5-voice x 64-cell staff image.
module midi_staff_writer
    import staff_pkg::*;
#(
    parameter int CELL_TICKS = 12_500_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        record_in,
    input  logic        midi_data_ready_in,
    input  logic        midi_status_in,
    input  logic [7:0]  midi_received_note_in,
    input  logic [7:0]  midi_velocity_in,
    output logic [NUM_VOICES-1:0][NUM_CELLS-1:0][11:0] note_memory_out,
    output logic        valid_staff_out,
    output logic        busy_out,
    output logic        overflow_out,
    output logic [5:0]  cell_idx_out
);

    localparam int TW = (CELL_TICKS > 1) ? $clog2(CELL_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CELL_TICKS - 1);
    localparam logic [NUM_VOICES*NUM_CELLS*12-1:0] REST_IMG = {NUM_VOICES*NUM_CELLS{REST_CODE}};

    staff_state_t state, state_nxt;
    logic [TW-1:0] tick;
    logic [5:0]    cell_idx;

    voice_t [NUM_VOICES-1:0] vt, vt_ev, vt_nxt;
    staff_entry_t [NUM_VOICES-1:0] col;
    logic [NUM_VOICES-1:0][3:0] oct, kind;

    logic              ev_ok, note_on, start, ev_apply, commit, last_cell;
    logic              hit, free_ok, ovf_set;
    logic [VIDX_W-1:0] free_idx;
    logic [6:0]        note7;

    // Bit 7 set is never a MIDI data byte; such events are dropped.
    assign note7    = midi_received_note_in[6:0];
    assign ev_ok    = midi_data_ready_in && !midi_received_note_in[7]
                      && (state == ST_ARMED || state == ST_RECORD);
    assign note_on  = midi_status_in && (midi_velocity_in != 8'd0);
    assign start    = (state == ST_ARMED) && record_in && ev_ok && note_on;
    assign ev_apply = start || (ev_ok && state == ST_RECORD);
    assign commit   = (state == ST_RECORD) && (!record_in || tick == TICK_LAST);
    assign last_cell = (cell_idx == 6'(NUM_CELLS - 1));

    // Event lands in the table first; the commit below sees the updated table.
    always_comb begin
        vt_ev    = start ? '0 : vt;
        hit      = 1'b0;
        free_ok  = 1'b0;
        free_idx = '0;
        ovf_set  = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (vt_ev[i].active && vt_ev[i].note == note7) begin
                hit = 1'b1;
                if (ev_apply && !note_on) vt_ev[i].rel = 1'b1;
            end else if (!vt_ev[i].active && !free_ok) begin
                free_ok  = 1'b1;
                free_idx = VIDX_W'(i);
            end
        end
        if (ev_apply && note_on && !hit) begin
            if (free_ok) vt_ev[free_idx] = '{active: 1'b1, rel: 1'b0, note: note7, held: 4'd1};
            else         ovf_set = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_split
        midi_note_split u_split (
            .note   (vt_ev[g].note),
            .octave (oct[g]),
            .kind   (kind[g])
        );
    end

    always_comb begin
        vt_nxt = vt_ev;
        for (int i = 0; i < NUM_VOICES; i++) begin
            col[i] = vt_ev[i].active ? staff_entry_t'({vt_ev[i].held, kind[i], oct[i]})
                                     : staff_entry_t'(REST_CODE);
            if (commit) begin
                if (vt_ev[i].rel)         vt_nxt[i]      = '0;
                else if (vt_ev[i].active) vt_nxt[i].held = sat_inc(vt_ev[i].held);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (record_in) state_nxt = ST_ARMED;
            ST_ARMED:  if (!record_in) state_nxt = ST_IDLE;
                       else if (start) state_nxt = ST_RECORD;
            ST_RECORD: if (commit && last_cell) state_nxt = ST_DONE;
                       else if (!record_in)     state_nxt = ST_FLUSH;
            ST_FLUSH:  if (last_cell) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            note_memory_out <= REST_IMG;
            vt              <= '0;
            tick            <= '0;
            cell_idx        <= '0;
            overflow_out    <= 1'b0;
        end else begin
            vt <= vt_nxt;
            if (start) begin
                note_memory_out <= REST_IMG;
                tick            <= '0;
                cell_idx        <= '0;
                overflow_out    <= 1'b0;
            end else begin
                if (ovf_set) overflow_out <= 1'b1;
                if (state == ST_RECORD) tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
                if (commit) begin
                    for (int v = 0; v < NUM_VOICES; v++) note_memory_out[v][cell_idx] <= col[v];
                    cell_idx <= cell_idx + 6'd1;
                end else if (state == ST_FLUSH) begin
                    for (int v = 0; v < NUM_VOICES; v++) note_memory_out[v][cell_idx] <= REST_CODE;
                    cell_idx <= cell_idx + 6'd1;
                end
            end
        end
    end

    assign valid_staff_out = (state == ST_DONE);
    assign busy_out        = (state == ST_ARMED) || (state == ST_RECORD) || (state == ST_FLUSH);
    assign cell_idx_out    = cell_idx;

endmodule

// File: tb/tb_midi_staff_writer.sv
// Bench for midi_staff_writer with 16-clock cells: event tables, image scoreboard, reset cases.
module tb_midi_staff_writer;
    import staff_pkg::*;

    localparam int CT = 16;

    logic clk_in = 1'b0, rst_in = 1'b0, record_in = 1'b0;
    logic midi_data_ready_in = 1'b0, midi_status_in = 1'b0;
    logic [7:0] midi_received_note_in = '0, midi_velocity_in = '0;
    logic [NUM_VOICES-1:0][NUM_CELLS-1:0][11:0] note_memory_out;
    logic valid_staff_out, busy_out, overflow_out;
    logic [5:0] cell_idx_out;

    always #5 clk_in = ~clk_in;

    midi_staff_writer #(.CELL_TICKS(CT)) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .record_in             (record_in),
        .midi_data_ready_in    (midi_data_ready_in),
        .midi_status_in        (midi_status_in),
        .midi_received_note_in (midi_received_note_in),
        .midi_velocity_in      (midi_velocity_in),
        .note_memory_out       (note_memory_out),
        .valid_staff_out       (valid_staff_out),
        .busy_out              (busy_out),
        .overflow_out          (overflow_out),
        .cell_idx_out          (cell_idx_out)
    );

    typedef struct {int t; logic st; logic [7:0] n; logic [7:0] vel;} ev_t;
    typedef struct {int v; int c; logic [11:0] e;} sb_t;
    typedef struct {logic [7:0] note; int off_t; logic v0; logic [11:0] e0; logic [11:0] e1;} vec_t;

    ev_t ev_q[$];
    sb_t sb[$];
    bit  listed [NUM_VOICES][NUM_CELLS];
    int  n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic add_ev(input int t, input logic st, input logic [7:0] n, input logic [7:0] vel);
        ev_q.push_back('{t: t, st: st, n: n, vel: vel});
    endtask

    task automatic expect_cell(input int v, input int c, input logic [11:0] e);
        sb.push_back('{v: v, c: c, e: e});
    endtask

    // Pops every queued expectation; all cells not named must hold the rest code.
    task automatic compare_image(input string tag);
        sb_t s;
        int  bad;
        for (int v = 0; v < NUM_VOICES; v++)
            for (int c = 0; c < NUM_CELLS; c++) listed[v][c] = 1'b0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            chk($sformatf("%s_v%0d_c%0d", tag, s.v, s.c), int'(note_memory_out[s.v][s.c]), int'(s.e));
            listed[s.v][s.c] = 1'b1;
        end
        bad = 0;
        for (int v = 0; v < NUM_VOICES; v++)
            for (int c = 0; c < NUM_CELLS; c++)
                if (!listed[v][c] && note_memory_out[v][c] != 12'h0F0) bad++;
        chk({tag, "_rest_cells_bad"}, bad, 0);
    endtask

    // t=0 is the clock edge that takes the first note-on; stop_t<0 keeps record_in high.
    task automatic play(input string tag, input int stop_t, input int exp_t, input logic exp_ovf);
        int got, pulses;
        got = -1;
        pulses = 0;
        record_in = 1'b1;
        @(negedge clk_in);
        chk({tag, "_armed_busy"}, int'(busy_out), 1);
        for (int t = 0; t < 1200; t++) begin
            midi_data_ready_in = 1'b0;
            record_in = (got < 0) && (stop_t < 0 || t < stop_t);
            foreach (ev_q[i]) if (ev_q[i].t == t) begin
                midi_data_ready_in    = 1'b1;
                midi_status_in        = ev_q[i].st;
                midi_received_note_in = ev_q[i].n;
                midi_velocity_in      = ev_q[i].vel;
            end
            @(negedge clk_in);
            if (t == 20 && (stop_t < 0 || stop_t > 20)) chk({tag, "_cell_idx"}, int'(cell_idx_out), 1);
            if (valid_staff_out) begin
                pulses++;
                if (got < 0) begin
                    got = t;
                    chk({tag, "_overflow"}, int'(overflow_out), int'(exp_ovf));
                    compare_image(tag);
                end
            end
            if (got >= 0 && t >= got + 5) break;
        end
        midi_data_ready_in = 1'b0;
        record_in = 1'b0;
        chk({tag, "_valid_time"}, got, exp_t);
        chk({tag, "_valid_pulses"}, pulses, 1);
        chk({tag, "_busy_after"}, int'(busy_out), 0);
        if (got < 0) compare_image(tag);
        ev_q.delete();
    endtask

    initial begin
        vec_t vecs[6];
        logic [11:0] poly_base[5];
        logic [7:0]  poly_note[6];
        int pulses;

        // Single-note vectors: octave = note/12, kind = note%12, dur in [11:8].
        vecs = '{
            '{note: 8'd0,   off_t: 3,  v0: 1'b0, e0: 12'h100, e1: 12'h0F0},
            '{note: 8'd11,  off_t: 20, v0: 1'b0, e0: 12'h1B0, e1: 12'h2B0},
            '{note: 8'd12,  off_t: 3,  v0: 1'b1, e0: 12'h101, e1: 12'h0F0},
            '{note: 8'd60,  off_t: 20, v0: 1'b0, e0: 12'h105, e1: 12'h205},
            '{note: 8'd127, off_t: 20, v0: 1'b1, e0: 12'h17A, e1: 12'h27A},
            '{note: 8'd69,  off_t: 3,  v0: 1'b0, e0: 12'h195, e1: 12'h0F0}
        };
        poly_note = '{8'd60, 8'd62, 8'd64, 8'd65, 8'd67, 8'd71};
        poly_base = '{12'h005, 12'h025, 12'h045, 12'h055, 12'h075};

        repeat (3) @(negedge clk_in);
        chk("reset_valid", int'(valid_staff_out), 0);
        chk("reset_busy", int'(busy_out), 0);
        chk("reset_overflow", int'(overflow_out), 0);
        chk("reset_cell_idx", int'(cell_idx_out), 0);
        compare_image("reset");
        rst_in = 1'b1;
        @(negedge clk_in);

        // Stop during cell 2 (t=40): valid at 40 + 61 flush clocks = 101.
        for (int i = 0; i < 6; i++) begin
            add_ev(0, 1'b1, vecs[i].note, 8'd100);
            if (vecs[i].v0) add_ev(vecs[i].off_t, 1'b1, vecs[i].note, 8'd0);
            else            add_ev(vecs[i].off_t, 1'b0, vecs[i].note, 8'd64);
            expect_cell(0, 0, vecs[i].e0);
            expect_cell(0, 1, vecs[i].e1);
            expect_cell(0, 2, REST_CODE);
            play($sformatf("vec%0d", i), 40, 101, 1'b0);
        end

        // Six held notes: five voices in arrival order, sixth dropped.
        for (int i = 0; i < 6; i++) add_ev(i, 1'b1, poly_note[i], 8'd90);
        for (int c = 0; c < 3; c++)
            for (int v = 0; v < 5; v++) expect_cell(v, c, poly_base[v] | 12'((c + 1) << 8));
        play("poly", 40, 101, 1'b1);

        // Unmatched off and duplicate on ignored; vel-0 on lands on cell 1 commit edge (t=32).
        add_ev(0, 1'b1, 8'd48, 8'd100);
        add_ev(5, 1'b0, 8'd50, 8'd10);
        add_ev(8, 1'b1, 8'd48, 8'd100);
        add_ev(32, 1'b1, 8'd48, 8'd0);
        expect_cell(0, 0, 12'h104);
        expect_cell(0, 1, 12'h204);
        expect_cell(0, 2, REST_CODE);
        expect_cell(1, 0, REST_CODE);
        play("vel0", 40, 101, 1'b0);

        // Stop in cell 10 (t=170): cell 10 committed, 53 flush clocks, valid at 223.
        add_ev(0, 1'b1, 8'd60, 8'd100);
        add_ev(165, 1'b0, 8'd60, 8'd0);
        for (int c = 0; c < 11; c++) expect_cell(0, c, 12'h005 | 12'((c + 1) << 8));
        expect_cell(0, 11, REST_CODE);
        play("early", 170, 223, 1'b0);

        // Full image: note 60 for 40 clocks, note 72 held to the end (dur saturates at 15).
        add_ev(0, 1'b1, 8'd60, 8'd100);
        add_ev(2, 1'b1, 8'd72, 8'd100);
        add_ev(40, 1'b0, 8'd60, 8'd0);
        expect_cell(0, 0, 12'h105);
        expect_cell(0, 1, 12'h205);
        expect_cell(0, 2, 12'h305);
        expect_cell(0, 3, REST_CODE);
        for (int c = 0; c < NUM_CELLS; c++)
            expect_cell(1, c, 12'h006 | 12'(((c < 15) ? c + 1 : 15) << 8));
        play("full", -1, 1024, 1'b0);

        // Async reset in the middle of a recording.
        record_in = 1'b1;
        @(negedge clk_in);
        for (int t = 0; t < 30; t++) begin
            midi_data_ready_in    = (t < 6);
            midi_status_in        = 1'b1;
            midi_received_note_in = (t < 6) ? poly_note[t] : 8'd0;
            midi_velocity_in      = 8'd80;
            @(negedge clk_in);
        end
        midi_data_ready_in = 1'b0;
        chk("rstmid_pre_busy", int'(busy_out), 1);
        chk("rstmid_pre_overflow", int'(overflow_out), 1);
        chk("rstmid_pre_c0", int'(note_memory_out[0][0]), 12'h105);
        #2 rst_in = 1'b0;
        #1;
        chk("rstmid_busy", int'(busy_out), 0);
        chk("rstmid_valid", int'(valid_staff_out), 0);
        chk("rstmid_overflow", int'(overflow_out), 0);
        chk("rstmid_cell_idx", int'(cell_idx_out), 0);
        compare_image("rstmid");
        record_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        pulses = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk_in);
            if (valid_staff_out) pulses++;
        end
        chk("rstmid_no_pulse", pulses, 0);
        chk("rstmid_idle_busy", int'(busy_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
